// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// uart_cmd_ctrl : one-frame-at-a-time command sequencer between the UART frame
//                 buffer, the AES core, the UART transmitter and the cat LEDs.
// Option macro  : UART_CMD_ERR_REPLY_EN (errors answer with an all-'?' frame)
// Revision      : 1.0
// ============================================================================
module uart_cmd_ctrl #(
  parameter int FRAME_BYTES  = 18,
  parameter int AES_TIMEOUT  = 4096,
  parameter int TIMEOUT_BITS = 13
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_valid,
  input  logic [FRAME_BYTES*8-1:0] frame,
  output logic [127:0]             aes_key,
  output logic [127:0]             aes_pt,
  output logic                     aes_start,
  input  logic                     aes_valid,
  input  logic [127:0]             aes_ct,
  input  logic                     tx_busy,
  output logic [FRAME_BYTES*8-1:0] tx_data,
  output logic                     tx_trigger,
  output logic [7:0]               cat_status,
  output logic [7:0]               err_count
);
  localparam int c_FW   = FRAME_BYTES * 8;
  localparam int c_LAST = FRAME_BYTES - 1;
  localparam logic [7:0] c_CMD_AT  = 8'h40;
  localparam logic [7:0] c_CMD_A   = 8'h41;
  localparam logic [7:0] c_CMD_B   = 8'h42;
  localparam logic [7:0] c_CMD_C   = 8'h43;
  localparam logic [7:0] c_ARG_S   = 8'h53;
  localparam logic [7:0] c_ARG_ALL = 8'h60;
`ifdef UART_CMD_ERR_REPLY_EN
  localparam logic [7:0] c_ERR_BYTE = 8'h3F;
`endif
  localparam logic [TIMEOUT_BITS-1:0] c_TMO_LAST = TIMEOUT_BITS'(AES_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHECK    = 3'd1,
    S_AES_WAIT = 3'd2,
    S_TX_WAIT  = 3'd3,
    S_TX_FIRE  = 3'd4
  } state_t;

  state_t                  r_state, w_next;
  logic [c_FW-1:0]         r_frame_q, r_tx_data, w_status_frame;
  logic [127:0]            r_aes_key, r_aes_pt, r_ct_q;
  logic [7:0]              r_cat, r_err;
  logic                    r_aes_start, r_tx_trigger;
  logic [TIMEOUT_BITS-1:0] r_tmo_cnt;
  logic [7:0]              w_b0, w_b1, w_b2, w_blast;
  logic                    w_term_ok, w_do_a, w_do_b, w_do_c, w_do_ct, w_do_st;
  logic                    w_dec_err, w_aes_done, w_tmo, w_drop;
  logic [2:0]              w_cat_idx;
  logic [1:0]              w_err_inc;
  logic [8:0]              w_err_sum;

  assign w_b0      = r_frame_q[7:0];
  assign w_b1      = r_frame_q[15:8];
  assign w_b2      = r_frame_q[23:16];
  assign w_blast   = r_frame_q[8*c_LAST +: 8];
  assign w_term_ok = (w_blast == w_b0);
  // 'A'..'H' map to LED bits 0..7 through their low three bits minus one
  assign w_cat_idx = w_b1[2:0] - 3'd1;
  assign w_drop    = frame_valid && (r_state != S_IDLE);
  assign w_err_inc = {1'b0, w_drop} + {1'b0, (w_dec_err | w_tmo)};
  assign w_err_sum = {1'b0, r_err} + {7'b0, w_err_inc};

  always_comb begin
    w_status_frame                = '0;
    w_status_frame[7:0]           = c_CMD_AT;
    w_status_frame[15:8]          = r_cat;
    w_status_frame[23:16]         = r_err;
    w_status_frame[8*c_LAST +: 8] = c_CMD_AT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_do_a     = 1'b0;
    w_do_b     = 1'b0;
    w_do_c     = 1'b0;
    w_do_ct    = 1'b0;
    w_do_st    = 1'b0;
    w_dec_err  = 1'b0;
    w_aes_done = 1'b0;
    w_tmo      = 1'b0;
    case (r_state)
      S_IDLE: if (frame_valid) w_next = S_CHECK;
      S_CHECK: begin
        w_next = S_IDLE;
        case (w_b0)
          c_CMD_A:
            if ((w_b2 == w_b0) && (((w_b1 >= c_CMD_A) && (w_b1 <= 8'h48)) || (w_b1 == c_ARG_ALL)))
              w_do_a = 1'b1;
            else
              w_dec_err = 1'b1;
          c_CMD_B:
            if (w_term_ok) w_do_b = 1'b1;
            else           w_dec_err = 1'b1;
          c_CMD_C:
            if (w_term_ok) begin
              w_do_c = 1'b1;
              w_next = S_AES_WAIT;
            end else begin
              w_dec_err = 1'b1;
            end
          c_CMD_AT:
            if (w_term_ok && (w_b1 == c_CMD_C)) begin
              w_do_ct = 1'b1;
              w_next  = S_TX_WAIT;
            end else if (w_term_ok && (w_b1 == c_ARG_S)) begin
              w_do_st = 1'b1;
              w_next  = S_TX_WAIT;
            end else begin
              w_dec_err = 1'b1;
            end
          default: w_dec_err = 1'b1;
        endcase
      end
      S_AES_WAIT: begin
        if (aes_valid) begin
          w_aes_done = 1'b1;
          w_next     = S_TX_WAIT;
        end else if (r_tmo_cnt == c_TMO_LAST) begin
          w_tmo  = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_TX_WAIT: if (!tx_busy) w_next = S_TX_FIRE;
      S_TX_FIRE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
`ifdef UART_CMD_ERR_REPLY_EN
    if (w_dec_err || w_tmo) w_next = S_TX_WAIT;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_q    <= '0;
      r_tx_data    <= '0;
      r_aes_key    <= '0;
      r_aes_pt     <= '0;
      r_ct_q       <= '0;
      r_cat        <= 8'hFF;
      r_err        <= 8'h00;
      r_aes_start  <= 1'b0;
      r_tx_trigger <= 1'b0;
      r_tmo_cnt    <= '0;
    end else begin
      r_aes_start  <= w_do_c;
      r_tx_trigger <= (r_state == S_TX_WAIT) && !tx_busy;
      r_err        <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
      if ((r_state == S_IDLE) && frame_valid) r_frame_q <= frame;
      if (w_do_c)                        r_tmo_cnt <= '0;
      else if (r_state == S_AES_WAIT)    r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (w_do_a) begin
        if (w_b1 == c_ARG_ALL) r_cat <= 8'hFF;
        else                   r_cat[w_cat_idx] <= 1'b0;
      end
      if (w_do_b) r_aes_key <= r_frame_q[8 +: 128];
      if (w_do_c) r_aes_pt  <= r_frame_q[8 +: 128];
      if (w_aes_done) r_ct_q <= aes_ct;
      // tx_data only loads on leaving CHECK/AES_WAIT, so it is stable while queued
      if (w_do_ct)         r_tx_data <= {c_CMD_C, r_ct_q, c_CMD_C};
      else if (w_do_st)    r_tx_data <= w_status_frame;
      else if (w_aes_done) r_tx_data <= {c_CMD_C, aes_ct, c_CMD_C};
`ifdef UART_CMD_ERR_REPLY_EN
      else if (w_dec_err || w_tmo) r_tx_data <= {FRAME_BYTES{c_ERR_BYTE}};
`endif
    end
  end

  assign aes_key    = r_aes_key;
  assign aes_pt     = r_aes_pt;
  assign aes_start  = r_aes_start;
  assign tx_data    = r_tx_data;
  assign tx_trigger = r_tx_trigger;
  assign cat_status = r_cat;
  assign err_count  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// tb_uart_cmd_ctrl : randomized frames checked against a transaction-level
//                    model of the command controller.
// Revision         : 1.0
// ============================================================================
module tb_uart_cmd_ctrl;
  localparam int c_TMO = 4096;

  logic         clk = 1'b0;
  logic         reset;
  logic         frame_valid;
  logic [143:0] frame;
  logic [127:0] aes_key, aes_pt, aes_ct;
  logic         aes_start, aes_valid, tx_busy, tx_trigger;
  logic [143:0] tx_data;
  logic [7:0]   cat_status, err_count;

  int n_checks = 0;
  int n_errs   = 0;

  logic [127:0] m_key, m_pt, m_ct;
  logic [7:0]   m_cat, m_err;

  uart_cmd_ctrl dut (
    .clk(clk), .reset(reset), .frame_valid(frame_valid), .frame(frame),
    .aes_key(aes_key), .aes_pt(aes_pt), .aes_start(aes_start),
    .aes_valid(aes_valid), .aes_ct(aes_ct), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_trigger(tx_trigger),
    .cat_status(cat_status), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [143:0] rnd144();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[143:0];
  endfunction

  function automatic logic [143:0] mk_frame(input logic [7:0] b0, b1, b2, bl);
    logic [143:0] f;
    f = rnd144();
    f[7:0] = b0; f[15:8] = b1; f[23:16] = b2; f[143:136] = bl;
    return f;
  endfunction

  // Stand-in for the AES core: any fixed mixing of key and plaintext will do
  function automatic logic [127:0] fake_aes(input logic [127:0] k, p);
    return k ^ {p[63:0], p[127:64]} ^ 128'hA5A5_0F0F_3C3C_9696_5A5A_F0F0_C3C3_6969;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic model_reset();
    m_key = '0; m_pt = '0; m_ct = '0; m_cat = 8'hFF; m_err = 8'h00;
  endtask

  // One frame end to end. lat<0: AES never answers. busy: cycles tx_busy stays
  // high from the frame cycle. drop_at>0: extra frame_valid in that cycle.
  task automatic run_txn(input logic [143:0] f, input int lat, input int busy, input int drop_at);
    logic [7:0]   b0, b1, b2, bl, idx;
    logic [143:0] exp_tx, cap;
    bit           exp_start, exp_tx_en, err, p_s, p_t;
    int           exp_trig, n_start, n_trig, start_cyc, trig_cyc, dbl, window, w;
    b0 = f[7:0]; b1 = f[15:8]; b2 = f[23:16]; bl = f[143:136];
    exp_start = 0; exp_tx_en = 0; err = 0; exp_trig = -1; exp_tx = '0;
    if (b0 == 8'h41) begin
      if (b2 == b0 && b1 >= 8'h41 && b1 <= 8'h48) begin
        idx = b1 - 8'h41;
        m_cat[idx[2:0]] = 1'b0;
      end else if (b2 == b0 && b1 == 8'h60) m_cat = 8'hFF;
      else err = 1;
    end else if (b0 == 8'h42 && bl == b0) begin
      m_key = f[135:8];
    end else if (b0 == 8'h43 && bl == b0) begin
      m_pt = f[135:8];
      exp_start = 1;
      if (lat >= 0) begin
        m_ct = fake_aes(m_key, m_pt);
        exp_tx_en = 1;
        exp_tx = {8'h43, m_ct, 8'h43};
        w = 2 + lat + 1;
        exp_trig = ((w > busy) ? w : busy) + 1;
      end else err = 1;
      if (drop_at > 0) m_err = sat_inc(m_err);
    end else if (b0 == 8'h40 && bl == b0 && (b1 == 8'h43 || b1 == 8'h53)) begin
      exp_tx_en = 1;
      if (b1 == 8'h43) exp_tx = {8'h43, m_ct, 8'h43};
      else begin
        exp_tx[7:0] = 8'h40; exp_tx[15:8] = m_cat; exp_tx[23:16] = m_err; exp_tx[143:136] = 8'h40;
      end
      exp_trig = ((busy > 2) ? busy : 2) + 1;
    end else err = 1;
    if (err) begin
      m_err = sat_inc(m_err);
`ifdef UART_CMD_ERR_REPLY_EN
      exp_tx_en = 1;
      exp_tx = {18{8'h3F}};
`endif
    end

    n_start = 0; n_trig = 0; start_cyc = -1; trig_cyc = -1; dbl = 0; cap = '0;
    p_s = 0; p_t = 0;
    window = (exp_start && lat < 0) ? c_TMO + 40 : 60 + busy + ((lat > 0) ? lat : 0);
    @(negedge clk);
    frame = f; frame_valid = 1'b1; tx_busy = (busy > 0);
    @(negedge clk);
    frame_valid = 1'b0;
    for (int cyc = 1; cyc <= window; cyc++) begin
      if (aes_start) begin n_start++; if (start_cyc < 0) start_cyc = cyc; end
      if (tx_trigger) begin n_trig++; if (trig_cyc < 0) begin trig_cyc = cyc; cap = tx_data; end end
      if ((aes_start && p_s) || (tx_trigger && p_t)) dbl++;
      p_s = aes_start; p_t = tx_trigger;
      aes_valid = 1'b0;
      aes_ct = rnd144()[127:0];
      if (start_cyc > 0 && lat >= 0 && cyc == start_cyc + lat) begin
        aes_valid = 1'b1;
        aes_ct = fake_aes(aes_key, aes_pt);
      end
      frame_valid = (cyc == drop_at);
      if (cyc == drop_at) frame = rnd144();
      if (cyc == busy) tx_busy = 1'b0;
      @(negedge clk);
    end
    aes_valid = 1'b0; frame_valid = 1'b0; tx_busy = 1'b0;

    check_val("n_start", n_start, exp_start);
    if (exp_start) check_val("start_cyc", start_cyc, 2);
    check_val("n_trig", n_trig, exp_tx_en);
    if (exp_tx_en) check_val("tx_data", cap, exp_tx);
    if (exp_trig > 0) check_val("trig_cyc", trig_cyc, exp_trig);
    check_val("dbl_pulse", dbl, 0);
    check_val("cat_status", cat_status, m_cat);
    check_val("err_count", err_count, m_err);
    check_val("aes_key", aes_key, m_key);
    check_val("aes_pt", aes_pt, m_pt);
  endtask

  initial begin
    int k, n_s, n_t, busy, lat, drop;
    logic [143:0] f;
    logic [7:0]   b;
    reset = 1'b1; frame_valid = 1'b0; frame = '0; aes_valid = 1'b0; aes_ct = '0; tx_busy = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_val("rst_cat", cat_status, 8'hFF);
    check_val("rst_err", err_count, 8'h00);
    check_val("rst_tx_data", tx_data, 144'h0);
    check_val("rst_key", aes_key, 128'h0);
    n_s = 0; n_t = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_s += int'(aes_start); n_t += int'(tx_trigger);
    end
    check_val("idle_start", n_s, 0);
    check_val("idle_trig", n_t, 0);

    run_txn(mk_frame(8'h41, 8'h43, 8'h41, 8'h00), 0, 0, -1);
    run_txn(mk_frame(8'h41, 8'h60, 8'h41, 8'h00), 0, 0, -1);
    run_txn(mk_frame(8'h41, 8'h5A, 8'h41, 8'h00), 0, 0, -1);
    run_txn({8'h42, 128'h000102030405060708090A0B0C0D0E0F, 8'h42}, 0, 0, -1);
    run_txn({8'h43, 128'h00112233445566778899AABBCCDDEEFF, 8'h43}, 10, 0, -1);
    run_txn(mk_frame(8'h40, 8'h53, 8'h00, 8'h40), 0, 50, -1);
    run_txn(mk_frame(8'h43, 8'h01, 8'h02, 8'h43), -1, 0, -1);
    run_txn(mk_frame(8'h43, 8'h03, 8'h04, 8'h43), 12, 0, 5);
    run_txn(mk_frame(8'h40, 8'h43, 8'h00, 8'h40), 0, 0, -1);

    for (int t = 0; t < 40; t++) begin
      k = $urandom_range(0, 9);
      busy = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 40);
      lat = $urandom_range(1, 30);
      drop = (lat >= 10 && $urandom_range(0, 1) == 1) ? 5 : -1;
      case (k)
        0, 1: begin
          k = $urandom_range(0, 8);
          b = (k == 8) ? 8'h60 : 8'h41 + 8'(k);
          f = mk_frame(8'h41, b, 8'h41, 8'h00);
        end
        2: f = mk_frame(8'h41, 8'h42, 8'h40, 8'h00);
        3: f = mk_frame(8'h42, 8'h00, 8'h00, 8'h42);
        4, 5: f = mk_frame(8'h43, 8'h00, 8'h00, 8'h43);
        6: f = mk_frame(8'h40, 8'h43, 8'h00, 8'h40);
        7: f = mk_frame(8'h40, 8'h53, 8'h00, 8'h40);
        8: f = mk_frame(8'h44 + 8'($urandom_range(0, 100)), 8'h00, 8'h00, 8'h00);
        default: f = mk_frame(8'h42, 8'h00, 8'h00, 8'h43);
      endcase
      f[143:136] = (k == 8 || k == 9) ? f[143:136] : f[143:136];
      run_txn(f, lat, busy, (k == 4 || k == 5) ? drop : -1);
    end

    // Reset in the middle of an encryption; the late result must be ignored
    @(negedge clk);
    frame = {8'h43, rnd144()[127:0], 8'h43}; frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_val("async_rst_err", err_count, 8'h00);
    check_val("async_rst_key", aes_key, 128'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    aes_valid = 1'b1; aes_ct = rnd144()[127:0];
    n_s = 0; n_t = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      aes_valid = 1'b0;
      n_s += int'(aes_start); n_t += int'(tx_trigger);
    end
    check_val("late_valid_trig", n_t, 0);
    check_val("late_valid_start", n_s, 0);
    run_txn(mk_frame(8'h40, 8'h43, 8'h00, 8'h40), 0, 0, -1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command sequencer between the UART core's receive frame buffer and the badge's shared resources (AES encryption core, UART transmitter, cat-status LEDs). Validates each received frame and decodes its command byte. Sequences AES key/plaintext loading and encryption, and arbitrates the single UART TX path between command replies, ciphertext returns and optional error replies. Replaces the free-running per-cycle decode in the top level with an explicit one-frame-at-a-time FSM.

## Interface
- FRAME_BYTES, 18: UART frame length in bytes; byte k = frame[8k+7:8k], byte 0 = command.
- AES_TIMEOUT, 4096: cycles to wait for aes_valid before abandoning an encryption.
- TIMEOUT_BITS, 13: counter width; must hold AES_TIMEOUT.

- clk  in  1  system clock (internal oscillator domain).
- reset  in  1  asynchronous, active-high reset.
- frame_valid  in  1  one-cycle pulse; frame holds a complete new frame.
- frame  in  FRAME_BYTES*8  received frame from UART core.
- aes_key  out  128  AES key register.
- aes_pt  out  128  AES plaintext register.
- aes_start  out  1  one-cycle encryption start pulse.
- aes_valid  in  1  encryption result valid (pulse or level).
- aes_ct  in  128  ciphertext from AES core.
- tx_busy  in  1  UART transmitter busy.
- tx_data  out  FRAME_BYTES*8  frame to transmit.
- tx_trigger  out  1  one-cycle transmit request.
- cat_status  out  8  active-low cat LED mask.
- err_count  out  8  saturating count of rejected/dropped frames.

## Operation
- States: IDLE, CHECK, AES_WAIT, TX_WAIT, TX_FIRE.
- IDLE: on frame_valid, register frame into frame_q -> CHECK. A frame_valid in any other state is dropped; err_count += 1.
- CHECK (1 cycle), decode byte 0 of frame_q:
  - 'A' (0x41): byte 2 must equal byte 0. Byte 1 in 'A'..'H' clears cat_status[byte1-0x41]; byte 1 '`' (0x60) sets cat_status = 0xFF. -> IDLE.
  - 'B' (0x42): byte 17 must equal byte 0. aes_key <= frame_q[135:8] -> IDLE.
  - 'C' (0x43): byte 17 must equal byte 0. aes_pt <= frame_q[135:8]; aes_start pulses; timeout counter cleared -> AES_WAIT.
  - '@' (0x40): byte 17 must equal byte 0. Byte 1 'C' loads tx_data = {'C', ct_q, 'C'} (byte 0 and byte 17 = 0x43, bytes 16..1 = ct_q). Byte 1 'S' loads tx_data: byte 0 = '@', byte 1 = cat_status, byte 2 = err_count, bytes 3..16 = 0, byte 17 = '@'. Either -> TX_WAIT.
  - Any other command, terminator mismatch or argument = error: err_count += 1 (saturate at 0xFF) -> IDLE.
- AES_WAIT: on aes_valid: ct_q <= aes_ct; tx_data <= {'C', aes_ct, 'C'} -> TX_WAIT. Counter reaching AES_TIMEOUT-1 without aes_valid = error -> IDLE; ct_q unchanged.
- TX_WAIT: when tx_busy = 0 -> TX_FIRE. TX_FIRE: tx_trigger = 1 for exactly one cycle -> IDLE.
- tx_data holds its value until the next load. It never changes while in TX_WAIT or TX_FIRE.
- Reset (any state, async): state IDLE; aes_key, aes_pt, ct_q, tx_data, err_count = 0; aes_start, tx_trigger = 0; cat_status = 0xFF. An in-flight AES result arriving after reset is ignored.

## Timing
- Cycle 0: frame_valid in IDLE. Cycle 1: CHECK. Cycle 2: decoded register updates visible; aes_start high for 'C'.
- '@' with tx_busy low: tx_trigger high in cycle 3.
- Ciphertext reply: tx_trigger no earlier than 2 cycles after the aes_valid cycle.
- aes_start and tx_trigger are registered outputs, never high for more than one consecutive cycle.
- Only one frame is in flight. The controller is ready for a new frame in the cycle after it returns to IDLE.

## Configuration
- UART_CMD_ERR_REPLY_EN defined: every error (decode error, AES timeout) loads tx_data with all bytes 0x3F ('?') and goes to TX_WAIT. Dropped frames (frame_valid while busy) still only count.
- Undefined: errors are silent; counted in err_count, -> IDLE, no TX.

## Test plan
- Reset with no stimulus -> cat_status = 0xFF, err_count = 0, tx_trigger and aes_start never assert.
- Frame 'A','C','A' -> cat_status = 0xFB; then 'A','`','A' -> 0xFF; then 'A','Z','A' -> unchanged, err_count = 1.
- 'B' + key 0x000102..0F + 'B', then 'C' + pt + 'C', model returns aes_valid 10 cycles after aes_start -> aes_key and aes_pt correct; one aes_start pulse; one tx_trigger; tx_data = 0x43 + ciphertext + 0x43.
- '@','S',...,'@' with tx_busy held high 50 cycles -> no tx_trigger until tx_busy falls, then exactly one pulse; byte 1 = cat_status.
- 'C' frame with aes_valid never asserted -> return to IDLE after 4096 cycles; err_count += 1; with UART_CMD_ERR_REPLY_EN, one tx_trigger with all-0x3F frame.
- frame_valid pulsed during AES_WAIT -> frame ignored, err_count += 1. Reset asserted mid-AES_WAIT, then late aes_valid -> no tx_trigger, ct_q = 0.
